// File: rtl/priv_1_11_clint.sv
// Core-local interruptor: MSIP/MTIME/MTIMECMP registers, level tracking and serialized mip set/clear pulses.
// Defining CLINT_EXT_IRQ_EN adds a synchronized external interrupt source at top priority.

module priv_1_11_clint #(
  parameter int PRESCALE = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ren,
  input  logic        wen,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        bus_err,
  output logic        soft_int_m,
  output logic        clear_soft_int_m,
  output logic        timer_int_m,
  output logic        clear_timer_int_m,
`ifdef CLINT_EXT_IRQ_EN
  input  logic        ext_irq,
`endif
  output logic        ext_int_m,
  output logic        clear_ext_int_m
);

  localparam logic [15:0] MSIP_ADDR    = 16'h0000;
  localparam logic [15:0] CMP_LO_ADDR  = 16'h4000;
  localparam logic [15:0] CMP_HI_ADDR  = 16'h4004;
  localparam logic [15:0] TIME_LO_ADDR = 16'hBFF8;
  localparam logic [15:0] TIME_HI_ADDR = 16'hBFFC;
  localparam logic [15:0] PRE_MAX      = 16'(PRESCALE - 1);

  // Source index doubles as priority: the highest index wins arbitration.
  localparam int SRC_TM = 0;
  localparam int SRC_SW = 1;
`ifdef CLINT_EXT_IRQ_EN
  localparam int SRC_EXT = 2;
  localparam int NSRC    = 3;
`else
  localparam int NSRC    = 2;
`endif

  logic [15:0]     word_addr;
  logic            unused_addr_bits;
  logic            sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi, mapped;
  logic            msip_reg;
  logic [63:0]     mtime_reg;
  logic [63:0]     mtimecmp_reg;
  logic [15:0]     pre_reg;
  logic [31:0]     rd_mux;
  logic [NSRC-1:0] lvl;
  logic [NSRC-1:0] lvl_q_reg;
  logic [NSRC-1:0] set_p_reg;
  logic [NSRC-1:0] clr_p_reg;
  logic [NSRC-1:0] pend_any;
  logic [NSRC-1:0] grant;
  logic [NSRC-1:0] set_pulse_reg;
  logic [NSRC-1:0] clr_pulse_reg;

  assign word_addr        = {addr[15:2], 2'b00};
  assign unused_addr_bits = &addr[1:0];

  assign sel_msip    = (word_addr == MSIP_ADDR);
  assign sel_cmp_lo  = (word_addr == CMP_LO_ADDR);
  assign sel_cmp_hi  = (word_addr == CMP_HI_ADDR);
  assign sel_time_lo = (word_addr == TIME_LO_ADDR);
  assign sel_time_hi = (word_addr == TIME_HI_ADDR);
  assign mapped      = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      msip_reg     <= 1'b0;
      mtimecmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (wen) begin
      if (sel_msip)   msip_reg            <= wdata[0];
      if (sel_cmp_lo) mtimecmp_reg[31:0]  <= wdata;
      if (sel_cmp_hi) mtimecmp_reg[63:32] <= wdata;
    end
  end

  // A software load of either MTIME half takes precedence over the tick and restarts the prescaler.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mtime_reg <= 64'd0;
      pre_reg   <= 16'd0;
    end else if (wen && (sel_time_lo || sel_time_hi)) begin
      if (sel_time_lo) mtime_reg[31:0]  <= wdata;
      if (sel_time_hi) mtime_reg[63:32] <= wdata;
      pre_reg <= 16'd0;
    end else if (pre_reg == PRE_MAX) begin
      mtime_reg <= mtime_reg + 64'd1;
      pre_reg   <= 16'd0;
    end else begin
      pre_reg <= pre_reg + 16'd1;
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    if (sel_msip)    rd_mux = {31'd0, msip_reg};
    if (sel_cmp_lo)  rd_mux = mtimecmp_reg[31:0];
    if (sel_cmp_hi)  rd_mux = mtimecmp_reg[63:32];
    if (sel_time_lo) rd_mux = mtime_reg[31:0];
    if (sel_time_hi) rd_mux = mtime_reg[63:32];
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rdata   <= 32'd0;
      rvalid  <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      rdata   <= ren ? rd_mux : 32'd0;
      rvalid  <= ren;
      bus_err <= (ren | wen) & ~mapped;
    end
  end

  assign lvl[SRC_TM] = (mtime_reg >= mtimecmp_reg);
  assign lvl[SRC_SW] = msip_reg;

`ifdef CLINT_EXT_IRQ_EN
  logic [1:0] ext_sync_reg;

  always_ff @(posedge CLK) begin
    if (!nRST) ext_sync_reg <= 2'b00;
    else       ext_sync_reg <= {ext_sync_reg[0], ext_irq};
  end

  assign lvl[SRC_EXT] = ext_sync_reg[1];
`endif

  always_comb begin
    grant = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (pend_any[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      assign pend_any[gi] = set_p_reg[gi] | clr_p_reg[gi];

      // A fresh edge overrides both an older pending event and the grant in the same cycle.
      always_ff @(posedge CLK) begin
        if (!nRST) begin
          lvl_q_reg[gi]     <= 1'b0;
          set_p_reg[gi]     <= 1'b0;
          clr_p_reg[gi]     <= 1'b0;
          set_pulse_reg[gi] <= 1'b0;
          clr_pulse_reg[gi] <= 1'b0;
        end else begin
          lvl_q_reg[gi]     <= lvl[gi];
          set_pulse_reg[gi] <= grant[gi] & set_p_reg[gi];
          clr_pulse_reg[gi] <= grant[gi] & clr_p_reg[gi];
          if (lvl[gi] && !lvl_q_reg[gi]) begin
            set_p_reg[gi] <= 1'b1;
            clr_p_reg[gi] <= 1'b0;
          end else if (!lvl[gi] && lvl_q_reg[gi]) begin
            set_p_reg[gi] <= 1'b0;
            clr_p_reg[gi] <= 1'b1;
          end else if (grant[gi]) begin
            set_p_reg[gi] <= 1'b0;
            clr_p_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign timer_int_m       = set_pulse_reg[SRC_TM];
  assign clear_timer_int_m = clr_pulse_reg[SRC_TM];
  assign soft_int_m        = set_pulse_reg[SRC_SW];
  assign clear_soft_int_m  = clr_pulse_reg[SRC_SW];
`ifdef CLINT_EXT_IRQ_EN
  assign ext_int_m         = set_pulse_reg[SRC_EXT];
  assign clear_ext_int_m   = clr_pulse_reg[SRC_EXT];
`else
  assign ext_int_m         = 1'b0;
  assign clear_ext_int_m   = 1'b0;
`endif

endmodule

// File: tb/tb_priv_1_11_clint.sv
// Bench for priv_1_11_clint: directed scenarios plus randomized bus traffic against an event-level model.
// Exercises the external source too when CLINT_EXT_IRQ_EN is defined.

module tb_priv_1_11_clint;

  localparam int P = 1;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        rvalid, bus_err;
  logic        soft_int_m, clear_soft_int_m, timer_int_m, clear_timer_int_m;
  logic        ext_int_m, clear_ext_int_m;
`ifdef CLINT_EXT_IRQ_EN
  logic        ext_irq = 1'b0;
`endif

  priv_1_11_clint #(.PRESCALE(P)) dut (
    .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .bus_err(bus_err),
    .soft_int_m(soft_int_m), .clear_soft_int_m(clear_soft_int_m),
    .timer_int_m(timer_int_m), .clear_timer_int_m(clear_timer_int_m),
`ifdef CLINT_EXT_IRQ_EN
    .ext_irq(ext_irq),
`endif
    .ext_int_m(ext_int_m), .clear_ext_int_m(clear_ext_int_m)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: architectural registers, last seen level, and one pending event per source (0 none, 1 set, 2 clear).
  logic [63:0] m_time, m_cmp;
  bit          m_msip, m_s1, m_s2;
  int          m_pre;
  bit          lq[3];
  int          pend[3];
  int          e_src, e_kind;
  bit          e_rvalid, e_err;
  logic [31:0] e_rdata;

  // Pulse bookkeeping, bit = 2*source + (set ? 1 : 0): 0 tm clr, 1 tm set, 2 sw clr, 3 sw set, 4 ext clr, 5 ext set.
  int n_pulse[6];
  int last_at[6];

  function automatic bit is_mapped(input logic [15:0] a);
    logic [15:0] w;
    w = a & 16'hFFFC;
    return (w == 16'h0000) || (w == 16'h4000) || (w == 16'h4004) || (w == 16'hBFF8) || (w == 16'hBFFC);
  endfunction

  function automatic logic [31:0] reg_value(input logic [15:0] a);
    case (a & 16'hFFFC)
      16'h0000: return {31'd0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_time[31:0];
      16'hBFFC: return m_time[63:32];
      default:  return 32'd0;
    endcase
  endfunction

  function automatic void model_reset();
    m_time = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_msip = 1'b0; m_pre = 0;
    m_s1 = 1'b0; m_s2 = 1'b0;
    for (int s = 0; s < 3; s++) begin lq[s] = 1'b0; pend[s] = 0; end
    e_src = -1; e_kind = 0; e_rvalid = 1'b0; e_err = 1'b0; e_rdata = 32'd0;
  endfunction

  function automatic void model_edge();
    bit lvl[3];
    logic [15:0] w;
    int win;
    if (!nRST) begin
      model_reset();
      return;
    end
    lvl[0] = (m_time >= m_cmp);
    lvl[1] = m_msip;
`ifdef CLINT_EXT_IRQ_EN
    lvl[2] = m_s2;
`else
    lvl[2] = 1'b0;
`endif
    win = -1;
    for (int s = 2; s >= 0; s--) if (pend[s] != 0 && win < 0) win = s;
    e_src = win;
    e_kind = (win >= 0) ? pend[win] : 0;
    if (win >= 0) pend[win] = 0;
    for (int s = 0; s < 3; s++) begin
      if (lvl[s] && !lq[s]) pend[s] = 1;
      else if (!lvl[s] && lq[s]) pend[s] = 2;
      lq[s] = lvl[s];
    end
    e_rvalid = ren;
    e_err = (ren || wen) && !is_mapped(addr);
    e_rdata = ren ? reg_value(addr) : 32'd0;
    w = addr & 16'hFFFC;
    if (wen && w == 16'h0000) m_msip = wdata[0];
    if (wen && w == 16'h4000) m_cmp[31:0] = wdata;
    if (wen && w == 16'h4004) m_cmp[63:32] = wdata;
    if (wen && (w == 16'hBFF8 || w == 16'hBFFC)) begin
      if (w == 16'hBFF8) m_time[31:0] = wdata;
      else m_time[63:32] = wdata;
      m_pre = 0;
    end else if (m_pre == P - 1) begin
      m_pre = 0;
      m_time = m_time + 64'd1;
    end else begin
      m_pre++;
    end
`ifdef CLINT_EXT_IRQ_EN
    m_s2 = m_s1;
    m_s1 = ext_irq;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [5:0] exp_pulses();
    logic [5:0] v;
    v = 6'd0;
    if (e_src >= 0) v[2 * e_src + ((e_kind == 1) ? 1 : 0)] = 1'b1;
    return v;
  endfunction

  task automatic clear_counts();
    for (int b = 0; b < 6; b++) begin n_pulse[b] = 0; last_at[b] = -1; end
  endtask

  int t10 = -1;

  task automatic tick();
    logic [5:0] obs;
    @(posedge CLK);
    model_edge();
    cyc++;
    if (m_time == 64'd10 && t10 < 0) t10 = cyc;
    #1;
    obs = {ext_int_m, clear_ext_int_m, soft_int_m, clear_soft_int_m, timer_int_m, clear_timer_int_m};
    for (int b = 0; b < 6; b++) if (obs[b]) begin n_pulse[b]++; last_at[b] = cyc; end
    chk("rvalid", 64'(rvalid), 64'(e_rvalid));
    chk("bus_err", 64'(bus_err), 64'(e_err));
    chk("pulses", 64'(obs), 64'(exp_pulses()));
    chk("one_pulse", 64'($countones(obs) <= 1), 64'd1);
    if (e_rvalid) chk("rdata", 64'(rdata), 64'(e_rdata));
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    wen = 1'b1; addr = a; wdata = d;
    tick();
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a);
    ren = 1'b1; addr = a;
    tick();
    ren = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int guard, j, r;
    model_reset();
    clear_counts();

    // Reset state
    nRST = 1'b0;
    idle(3);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_pulses", 64'({ext_int_m, clear_ext_int_m, soft_int_m, clear_soft_int_m, timer_int_m, clear_timer_int_m}), 64'd0);
    nRST = 1'b1;

    // Reset value of MTIMECMP hi, then a quiet period
    bus_read(16'h4004);
    chk("cmp_hi_rst", 64'(rdata), 64'h0000_0000_FFFF_FFFF);
    clear_counts();
    idle(100);
    chk("quiet_pulses", 64'(n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3] + n_pulse[4] + n_pulse[5]), 64'd0);

    // Timer set when MTIME reaches 10, then clear when MTIMECMP is pushed away
    bus_write(16'h4004, 32'd0);
    bus_write(16'hBFF8, 32'd0);
    bus_write(16'hBFFC, 32'd0);
    clear_counts();
    t10 = -1;
    bus_write(16'h4000, 32'd10);
    idle(20);
    chk("tm_set_count", 64'(n_pulse[1]), 64'd1);
    chk("tm_set_latency", 64'(last_at[1] - t10), 64'd2);
    clear_counts();
    bus_write(16'h4000, 32'hFFFF_FFFF);
    idle(8);
    chk("tm_clr_count", 64'(n_pulse[0]), 64'd1);
    chk("tm_no_set", 64'(n_pulse[1]), 64'd0);

    // MSIP write on the same edge the timer level rises
    v = m_time[31:0] + 32'd6;
    bus_write(16'h4000, v);
    guard = 0;
    while (m_time[31:0] != v - 32'd1 && guard < 50) begin tick(); guard++; end
    chk("align_guard", 64'(guard < 50), 64'd1);
    clear_counts();
    bus_write(16'h0000, 32'd1);
    idle(6);
    chk("both_soft", 64'(n_pulse[3]), 64'd1);
    chk("both_timer", 64'(n_pulse[1]), 64'd1);
    chk("soft_then_timer", 64'(last_at[1] - last_at[3]), 64'd1);

    // MSIP 1 then 0 back to back while a timer clear contends
    bus_write(16'h0000, 32'd0);
    idle(6);
    clear_counts();
    bus_write(16'h4000, 32'hFFFF_FFFF);
    bus_write(16'h0000, 32'd1);
    bus_write(16'h0000, 32'd0);
    idle(8);
    chk("flip_soft_clr", 64'(n_pulse[2]), 64'd1);
    chk("flip_clr_last", 64'(last_at[2] > last_at[3]), 64'd1);
    chk("flip_tm_clr", 64'(n_pulse[0]), 64'd1);

    // 64-bit wrap of MTIME against an all-ones compare value
    bus_write(16'h4004, 32'hFFFF_FFFF);
    bus_write(16'h4000, 32'hFFFF_FFFF);
    bus_write(16'hBFFC, 32'hFFFF_FFFF);
    clear_counts();
    bus_write(16'hBFF8, 32'hFFFF_FFFE);
    idle(8);
    chk("wrap_set", 64'(n_pulse[1]), 64'd1);
    chk("wrap_clr", 64'(n_pulse[0]), 64'd1);
    chk("wrap_order", 64'(last_at[0] - last_at[1]), 64'd1);
    bus_read(16'hBFFC);
    chk("wrap_hi", 64'(rdata), 64'd0);

    // Unmapped accesses
    bus_read(16'h1234);
    chk("unm_rdata", 64'(rdata), 64'd0);
    chk("unm_rd_err", 64'(bus_err), 64'd1);
    bus_write(16'h1234, 32'h5A5A_5A5B);
    chk("unm_wr_err", 64'(bus_err), 64'd1);
    bus_read(16'h4000);
    chk("unm_cmp_kept", 64'(rdata), 64'h0000_0000_FFFF_FFFF);
    bus_read(16'h0000);
    chk("unm_msip_kept", 64'(rdata), 64'd0);

`ifdef CLINT_EXT_IRQ_EN
    // External rise pre-empts a soft event pending in the same cycle
    clear_counts();
    ext_irq = 1'b1;
    tick();
    j = cyc;
    bus_write(16'h0000, 32'd1);
    idle(6);
    chk("ext_set", 64'(n_pulse[5]), 64'd1);
    chk("ext_latency", 64'(last_at[5] - j), 64'd3);
    chk("ext_preempt", 64'(last_at[3] - last_at[5]), 64'd1);
    ext_irq = 1'b0;
    bus_write(16'h0000, 32'd0);
    idle(8);
`endif

    // Randomized traffic, including occasional mid-run resets
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      nRST = ($urandom_range(0, 149) != 0);
      ren = 1'b0;
      wen = 1'b0;
      if (r < 30) wen = 1'b1;
      else if (r < 50) ren = 1'b1;
      case ($urandom_range(0, 5))
        0: addr = 16'h0000;
        1: addr = 16'h4000;
        2: addr = 16'h4004;
        3: addr = 16'hBFF8;
        4: addr = 16'hBFFC;
        default: addr = 16'($urandom);
      endcase
      addr = addr | 16'($urandom_range(0, 3));
      if ((addr & 16'hFFFC) == 16'h4004 || (addr & 16'hFFFC) == 16'hBFFC)
        wdata = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'd0;
      else if ((addr & 16'hFFFC) == 16'h0000)
        wdata = $urandom;
      else
        wdata = $urandom_range(0, 400);
`ifdef CLINT_EXT_IRQ_EN
      if ($urandom_range(0, 19) == 0) ext_irq = ~ext_irq;
`endif
      tick();
    end
    nRST = 1'b1;
    ren = 1'b0;
    wen = 1'b0;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
